alu_issue: RTL and testbench

Issue and writeback stage sitting directly upstream of the 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8 x 8-bit register file. It drives the ALU operand, opcode and shift-amount inputs, captures the ALU result and flags one cycle later, and writes them back to the register file and the architectural flags register.

---
 rtl/alu_issue.sv | 114 +++++++++++
 tb/tb_alu_issue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/writeback stage feeding an 8-bit ALU with one-cycle registered latency.
// Holds the 8x8 register file, the instruction register and the architectural flags.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        busy,
  input  logic [2:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  rf_q [8];
  logic [7:0]  rf_d [8];
  logic [3:0]  flags_q, flags_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [2:0]  rd_s, rs1_s, rs2_s;

  assign rd_s  = ir_q[11:9];
  assign rs1_s = ir_q[8:6];
  assign rs2_s = ir_q[5:3];

  // r0 is hardwired to zero on every read port
  assign alu_a     = (rs1_s == 3'd0) ? 8'h00 : rf_q[rs1_s];
  assign alu_b     = (rs2_s == 3'd0) ? 8'h00 : rf_q[rs2_s];
  assign dbg_data  = (dbg_sel == 3'd0) ? 8'h00 : rf_q[dbg_sel];
  assign alu_op    = ir_q[15:12];
  assign alu_shamt = ir_q[2:0];

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign flags       = flags_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        // Writeback shares its edge with the next accept, so a dependent
        // instruction sees the new value in its EXEC cycle without forwarding.
        if (rd_s != 3'd0) begin
          rf_d[rd_s] = alu_out;
        end else begin
          rf_d[0] = 8'h00;
        end
        flags_d = alu_flags;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d != ST_EXEC);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
      flags_q <= 4'h0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random instruction
// streams compared against an instruction-level register-file model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [2:0]  alu_shamt;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        busy;
  logic [2:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_rf [8];
  logic [3:0] ref_flags;
  bit         pend_v;
  logic [2:0] pend_rd;
  logic [7:0] pend_out;
  logic [3:0] pend_fl;

  bit         ovr_en;
  logic [7:0] ovr_out;
  logic [3:0] ovr_fl;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_shamt(alu_shamt), .alu_out(alu_out), .alu_flags(alu_flags),
    .flags(flags), .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural ALU: returns {zero, negative, parity, carry, result}
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op, input logic [2:0] sh);
    logic [8:0] w;
    logic [7:0] r;
    case (op)
      4'h0:    w = {1'b0, a} + {1'b0, b};
      4'h1:    w = {1'b0, a} - {1'b0, b};
      4'h2:    w = {1'b0, a & b};
      4'h3:    w = {1'b0, a | b};
      4'h4:    w = {1'b0, a ^ b};
      4'h5:    w = {1'b0, a} << sh;
      4'h6:    w = {1'b0, a >> sh};
      default: w = {1'b0, (a ^ b) + {4'h0, op}};
    endcase
    r = w[7:0];
    return {(r == 8'h00), r[7], ^r, w[8], r};
  endfunction

  // Registered ALU with one-cycle latency; override lets a test force a result
  always @(posedge clk) begin
    if (ovr_en) begin
      alu_out   <= ovr_out;
      alu_flags <= ovr_fl;
    end else begin
      {alu_flags, alu_out} <= alu_f(alu_a, alu_b, alu_op, alu_shamt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit();
    if (pend_v) begin
      if (pend_rd != 3'd0) ref_rf[pend_rd] = pend_out;
      ref_flags = pend_fl;
      pend_v = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    ref_flags = 4'h0;
    pend_v = 1'b0;
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = i[2:0];
      #1;
      chk($sformatf("dbg_r%0d", i), {24'h0, dbg_data}, {24'h0, ref_rf[i]});
    end
    chk("flags", {28'h0, flags}, {28'h0, ref_flags});
  endtask

  task automatic peek(input logic [2:0] sel, output logic [7:0] val);
    dbg_sel = sel;
    #1;
    val = dbg_data;
  endtask

  // Issue one instruction from IDLE or WB; returns positioned in its WB cycle
  task automatic exec_wb(input logic [15:0] ins, input bit use_ovr, input logic [7:0] oo,
                         input logic [3:0] of, input bit exec_valid, input logic [15:0] exec_ins);
    logic [7:0]  ea, eb;
    logic [11:0] res;
    chk("ready_accept", {31'h0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    ovr_en      = use_ovr;
    ovr_out     = oo;
    ovr_fl      = of;
    @(posedge clk); #1;
    instr_valid = exec_valid;
    instr       = exec_ins;
    commit();
    ea = ref_rf[ins[8:6]];
    eb = ref_rf[ins[5:3]];
    chk("exec_alu_a", {24'h0, alu_a}, {24'h0, ea});
    chk("exec_alu_b", {24'h0, alu_b}, {24'h0, eb});
    chk("exec_alu_op", {28'h0, alu_op}, {28'h0, ins[15:12]});
    chk("exec_shamt", {29'h0, alu_shamt}, {29'h0, ins[2:0]});
    chk("exec_ready", {31'h0, instr_ready}, 32'd0);
    chk("exec_busy", {31'h0, busy}, 32'd1);
    chk_regs();
    res = use_ovr ? {of, oo} : alu_f(ea, eb, ins[15:12], ins[2:0]);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    pend_v   = 1'b1;
    pend_rd  = ins[11:9];
    pend_out = res[7:0];
    pend_fl  = res[11:8];
    chk("wb_ready", {31'h0, instr_ready}, 32'd1);
    chk("wb_busy", {31'h0, busy}, 32'd1);
    chk("wb_ir_kept", {28'h0, alu_op}, {28'h0, ins[15:12]});
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      commit();
      chk("idle_ready", {31'h0, instr_ready}, 32'd1);
      chk("idle_busy", {31'h0, busy}, 32'd0);
      chk_regs();
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] ins, junk;
    rst_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0; dbg_sel = 3'd0;
    ovr_en = 1'b0; ovr_out = 8'h00; ovr_fl = 4'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, instr_ready}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_alu_a", {24'h0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'h0, alu_b}, 32'd0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'd0);
    chk("rst_shamt", {29'h0, alu_shamt}, 32'd0);
    chk_regs();
    rst_n = 1'b1;

    // Reset in the middle of WB aborts the write to r3
    exec_wb({4'h3, 3'd3, 3'd0, 3'd0, 3'd0}, 1'b1, 8'hAA, 4'h9, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    clear_model();
    peek(3'd3, v);
    chk("rstwb_r3", {24'h0, v}, 32'd0);
    chk("rstwb_flags", {28'h0, flags}, 32'd0);
    chk("rstwb_ready", {31'h0, instr_ready}, 32'd1);
    chk("rstwb_busy", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Preload r1/r2, then a single add of them into r3
    exec_wb({4'h7, 3'd1, 3'd0, 3'd0, 3'd0}, 1'b1, 8'h12, 4'h1, 1'b0, 16'h0000);
    exec_wb({4'h7, 3'd2, 3'd0, 3'd0, 3'd0}, 1'b1, 8'h34, 4'h1, 1'b0, 16'h0000);
    idle(1);
    exec_wb({4'h0, 3'd3, 3'd1, 3'd2, 3'd5}, 1'b0, 8'h00, 4'h0, 1'b0, 16'h0000);
    idle(1);
    peek(3'd3, v);
    chk("single_r3", {24'h0, v}, 32'h46);
    chk("single_flags", {28'h0, flags}, 32'h2);

    // Back-to-back dependency: B reads r4 written by A one instruction earlier
    exec_wb({4'h8, 3'd4, 3'd1, 3'd2, 3'd0}, 1'b1, 8'h55, 4'h4, 1'b0, 16'h0000);
    exec_wb({4'h4, 3'd5, 3'd4, 3'd1, 3'd0}, 1'b0, 8'h00, 4'h0, 1'b0, 16'h0000);
    idle(1);

    // r0 never changes but flags still retire; rs1=0 reads zero
    exec_wb({4'h2, 3'd0, 3'd0, 3'd1, 3'd1}, 1'b1, 8'hFF, 4'hF, 1'b0, 16'h0000);
    idle(1);
    peek(3'd0, v);
    chk("r0_dbg", {24'h0, v}, 32'd0);
    chk("r0_flags", {28'h0, flags}, 32'hF);

    // Valid during EXEC is ignored; the same instruction held into WB is taken
    junk = {4'h9, 3'd6, 3'd3, 3'd5, 3'd2};
    exec_wb({4'h3, 3'd5, 3'd1, 3'd2, 3'd0}, 1'b0, 8'h00, 4'h0, 1'b1, junk);
    exec_wb(junk, 1'b0, 8'h00, 4'h0, 1'b0, 16'h0000);

    // Long idle gap: nothing may change
    idle(10);

    // Random instruction stream, mixing back-to-back issue and idle gaps
    for (int n = 0; n < 80; n++) begin
      ins  = 16'($urandom);
      junk = 16'($urandom);
      exec_wb(ins, 1'b0, 8'h00, 4'h0, 1'($urandom_range(0, 1)), junk);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
